// File: rtl/adc_sample_sequencer.sv
// Sequences SAR ADC conversions (periodic or single shot), resynchronises the
// done flag, and buffers 16-bit results in a show-ahead FIFO read via valid/ready.
module adc_sample_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_in,
  input  logic                        single_shot_in,
  input  logic [15:0]                 interval_in,
  output logic                        start_conversion_out,
  input  logic                        conversion_finished_in,
  input  logic [15:0]                 result_in,
  output logic                        rd_valid_out,
  input  logic                        rd_ready_in,
  output logic [15:0]                 rd_data_out,
  output logic [$clog2(FIFO_DEPTH):0] fill_level_out,
  output logic                        overflow_out,
  output logic                        timeout_out,
  input  logic                        clear_flags_in
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, WAIT_LOW, INTERVAL} state_t;

  state_t        state, state_nxt;
  logic          oneshot, oneshot_nxt;
  logic          start_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   ivl_cnt, ivl_nxt;
  logic          wr_en, tmo_set;

  // done flag resync; fin_d holds the previous fin_s for edge detection
  logic fin_m, fin_s, fin_d, fin_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_m <= 1'b0;
      fin_s <= 1'b0;
      fin_d <= 1'b0;
    end else begin
      fin_m <= conversion_finished_in;
      fin_s <= fin_m;
      fin_d <= fin_s;
    end
  end

  assign fin_rise = fin_s & ~fin_d;

  // tmo_cnt holds (cycles already spent in WAIT_DONE); abandon on the last allowed one
  always_comb begin
    state_nxt   = state;
    oneshot_nxt = oneshot;
    ivl_nxt     = ivl_cnt;
    wr_en       = 1'b0;
    tmo_set     = 1'b0;
    case (state)
      IDLE: begin
        if (single_shot_in) begin
          state_nxt   = START;
          oneshot_nxt = 1'b1;
        end else if (enable_in) begin
          state_nxt = START;
        end
      end
      START: begin
        if (start_cnt) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fin_rise) begin
          wr_en     = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!fin_s) begin
          if (oneshot || !enable_in) begin
            oneshot_nxt = 1'b0;
            state_nxt   = IDLE;
          end else if (interval_in == 16'd0) begin
            state_nxt = START;
          end else begin
            ivl_nxt   = interval_in;
            state_nxt = INTERVAL;
          end
        end
      end
      INTERVAL: begin
        if (!enable_in)            state_nxt = IDLE;
        else if (ivl_cnt == 16'd1) state_nxt = START;
        else                       ivl_nxt   = ivl_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      oneshot              <= 1'b0;
      start_cnt            <= 1'b0;
      tmo_cnt              <= '0;
      ivl_cnt              <= '0;
      start_conversion_out <= 1'b0;
    end else begin
      state                <= state_nxt;
      oneshot              <= oneshot_nxt;
      ivl_cnt              <= ivl_nxt;
      start_cnt            <= (state == START) && !start_cnt;
      tmo_cnt              <= (state == WAIT_DONE) ? tmo_cnt + TW'(1) : '0;
      start_conversion_out <= (state_nxt == START);
    end
  end

  // result FIFO: pointers carry one wrap bit above the address
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic          full, empty, rd_en, wr_ok, ovf_set;

  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty      = (wr_ptr == rd_ptr);
  assign rd_en      = !empty && rd_ready_in;
  assign wr_ok      = wr_en && (!full || rd_en);
  assign ovf_set    = wr_en && full && !rd_en;
  assign wr_ptr_nxt = wr_ptr + PW'(wr_ok);
  assign rd_ptr_nxt = rd_ptr + PW'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= result_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level_out <= '0;
      rd_valid_out   <= 1'b0;
      overflow_out   <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      fill_level_out <= wr_ptr_nxt - rd_ptr_nxt;
      rd_valid_out   <= (wr_ptr_nxt != rd_ptr_nxt);
      // a set event in the same cycle beats the clear
      if (ovf_set)             overflow_out <= 1'b1;
      else if (clear_flags_in) overflow_out <= 1'b0;
      if (tmo_set)             timeout_out  <= 1'b1;
      else if (clear_flags_in) timeout_out  <= 1'b0;
    end
  end

  assign rd_data_out = rd_valid_out ? mem[rd_ptr[AW-1:0]] : 16'd0;

endmodule
